// File: rtl/fp32_to_int_converter.sv
// fp32 -> int32/uint32 converter. Round toward zero, saturating.
// The significand is aligned by a 1-bit-per-cycle shifter. Flags report
// NaN/inf/out-of-range (invalid) and truncation loss (inexact).
module fp32_to_int_converter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_fp,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_int,
  output logic            out_invalid,
  output logic            out_inexact
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_FINISH   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]      state;
  logic [31:0]     op_fp;
  logic            op_signed;
  logic [31:0]     mag;
  logic [4:0]      cnt;
  logic            dir_left;
  logic            sticky;
  logic            ovf;      // exponent out of range before any shifting
  logic            is_nan;

  // Operand field decode; e is the unbiased exponent.
  logic            sign;
  logic [7:0]      exp_f;
  logic [22:0]     frac;
  logic signed [9:0] e;
  logic [4:0]      nd;

  assign sign  = op_fp[31];
  assign exp_f = op_fp[30:23];
  assign frac  = op_fp[22:0];
  assign e     = $signed({2'b00, exp_f}) - 10'sd127;
  assign nd    = (e >= 10'sd23) ? 5'(e - 10'sd23) : 5'(10'sd23 - e);

  assign in_ready = (state == S_IDLE);

  // Range check, sign application and saturation for the FINISH cycle.
  logic [31:0] res_val;
  logic        res_inv;

  always_comb begin
    res_val = mag;
    res_inv = 1'b0;
    if (op_signed) begin
      if (ovf) begin
        res_inv = 1'b1;
        res_val = (is_nan || !sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (!sign && mag > 32'h7FFF_FFFF) begin
        res_inv = 1'b1;
        res_val = 32'h7FFF_FFFF;
      end else if (sign && mag > 32'h8000_0000) begin
        res_inv = 1'b1;
        res_val = 32'h8000_0000;
      end else begin
        res_val = sign ? (~mag + 32'd1) : mag;
      end
    end else begin
      if (ovf) begin
        res_inv = 1'b1;
        res_val = (is_nan || !sign) ? 32'hFFFF_FFFF : 32'h0000_0000;
      end else if (sign && mag != 32'd0) begin
        res_inv = 1'b1;
        res_val = 32'h0000_0000;
      end else begin
        res_val = mag;
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_fp       <= '0;
      op_signed   <= 1'b0;
      mag         <= '0;
      cnt         <= '0;
      dir_left    <= 1'b0;
      sticky      <= 1'b0;
      ovf         <= 1'b0;
      is_nan      <= 1'b0;
      out_valid   <= 1'b0;
      out_int     <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_fp     <= in_fp;
            op_signed <= in_signed;
            sticky    <= 1'b0;
            ovf       <= 1'b0;
            is_nan    <= 1'b0;
            dir_left  <= 1'b0;
            state     <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          cnt <= '0;
          if (exp_f == 8'hFF || e >= 10'sd32) begin
            ovf    <= 1'b1;
            is_nan <= (exp_f == 8'hFF) && (frac != 23'd0);
            mag    <= '0;
            state  <= S_FINISH;
          end else if (e < 10'sd0) begin
            // |x| < 1: truncates to zero, inexact unless the operand is a zero
            mag    <= '0;
            sticky <= |op_fp[30:0];
            state  <= S_FINISH;
          end else begin
            mag      <= {8'd0, 1'b1, frac};
            dir_left <= (e >= 10'sd23);
            cnt      <= nd;
            state    <= (nd == 5'd0) ? S_FINISH : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (dir_left) begin
            mag <= mag << 1;
          end else begin
            mag    <= mag >> 1;
            sticky <= sticky | mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= S_FINISH;
        end
        S_FINISH: begin
          out_int     <= res_val;
          out_invalid <= res_inv;
          out_inexact <= sticky & ~res_inv;
          state       <= S_DONE;
        end
        S_DONE: begin
          // out_valid rises one cycle after entering DONE, then holds for the consumer
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int_converter.sv
// Self-checking bench for fp32_to_int_converter: directed corner cases plus
// randomized operands compared against an arithmetic reference model.
module tb_fp32_to_int_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_fp = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_int;
  logic        out_invalid;
  logic        out_inexact;

  int n_vec = 0;
  int n_err = 0;

  fp32_to_int_converter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact value of the float as a 64-bit integer, truncated toward
  // zero, then clipped to the target range.
  task automatic model(input logic [31:0] fp, input logic sg,
                       output logic [31:0] r, output logic inv, output logic inx,
                       output int lat);
    int          ex;
    logic [63:0] sig, m;
    longint      v;
    logic        s, nan, big;
    s   = fp[31];
    ex  = int'(fp[30:23]) - 127;
    sig = {40'd0, 1'b1, fp[22:0]};
    nan = (fp[30:23] == 8'hFF) && (fp[22:0] != 0);
    big = (fp[30:23] == 8'hFF) || ex >= 40;
    inx = 1'b0;
    inv = 1'b0;
    m   = 64'd0;
    lat = 3;
    if (!big) begin
      if (ex < 0) begin
        inx = (fp[30:0] != 0);
      end else if (ex >= 23) begin
        m = sig << (ex - 23);
      end else begin
        m   = sig >> (23 - ex);
        inx = (sig & ((64'd1 << (23 - ex)) - 1)) != 0;
      end
      if (ex >= 0 && ex < 32) lat = 3 + ((ex >= 23) ? ex - 23 : 23 - ex);
    end
    v = s ? -longint'(m) : longint'(m);
    if (sg) begin
      if (big) begin
        inv = 1; r = (nan || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (v > 64'sd2147483647) begin
        inv = 1; r = 32'h7FFF_FFFF;
      end else if (v < -64'sd2147483648) begin
        inv = 1; r = 32'h8000_0000;
      end else r = v[31:0];
    end else begin
      if (big) begin
        inv = 1; r = (nan || !s) ? 32'hFFFF_FFFF : 32'h0;
      end else if (v > 64'sd4294967295) begin
        inv = 1; r = 32'hFFFF_FFFF;
      end else if (v < 0) begin
        inv = 1; r = 32'h0;
      end else r = v[31:0];
    end
    if (inv) inx = 1'b0;
  endtask

  // One full transaction: offer, wait for result, hold off consumer, retire.
  task automatic run(input logic [31:0] fp, input logic sg, input int hold);
    logic [31:0] r;
    logic        inv, inx;
    int          lat, n, g;
    model(fp, sg, r, inv, inx, lat);
    @(negedge clk);
    in_fp = fp; in_signed = sg; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("accept_timeout", 32'(g), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; in_fp = $urandom; in_signed = ~sg;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!out_valid && n < 100);
    chk($sformatf("lat %h", fp), 32'(n), 32'(lat));
    chk($sformatf("int %h s%0d", fp, sg), out_int, r);
    chk($sformatf("inv %h s%0d", fp, sg), 32'(out_invalid), 32'(inv));
    chk($sformatf("inx %h s%0d", fp, sg), 32'(out_inexact), 32'(inx));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_int", out_int, r);
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("rdy_after", 32'(in_ready), 32'd1);
    chk("vld_after", 32'(out_valid), 32'd0);
    chk("int_kept", out_int, r);
  endtask

  initial begin
    logic [31:0] fp;
    // reset state
    #12;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_int", out_int, 32'd0);
    chk("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // directed corners
    run(32'h404CCCCD, 1, 0);   // 3.2 -> 3 inexact, 25 cycles
    run(32'hC28C3EFA, 1, 0);   // -70.123 -> -70
    run(32'h4171999A, 1, 1);   // 15.1 -> 15
    run(32'h4F000000, 1, 0);   // 2^31 signed -> sat
    run(32'h4F000000, 0, 0);   // 2^31 unsigned exact
    run(32'hCF000000, 1, 0);   // -2^31 exact
    run(32'h7FC00000, 1, 0);   // NaN
    run(32'h7FC00000, 0, 0);
    run(32'hFF800000, 1, 0);   // -inf
    run(32'h7F800000, 0, 0);   // +inf
    run(32'hBF800000, 0, 0);   // -1.0 unsigned invalid
    run(32'hBF000000, 0, 0);   // -0.5 unsigned inexact only
    run(32'h80000000, 1, 0);   // -0
    run(32'h00000000, 0, 0);
    run(32'h00000001, 1, 0);   // denormal
    run(32'h4F7FFFFF, 0, 0);   // largest uint-range value (e=31)
    run(32'h4F800000, 0, 0);   // 2^32 unsigned overflow
    run(32'h3F800000, 1, 0);   // 1.0, max right shift
    run(32'h4B000001, 1, 0);   // e=23, no shift
    run(32'h41200000, 1, 10);  // backpressure

    // reset during SHIFT
    @(negedge clk);
    in_fp = 32'h3F800001; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_int", out_int, 32'd0);
    chk("mid_rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run(32'h41200000, 1, 0);   // 10.0 -> 10

    // randomized, exponents biased around the interesting range
    for (int k = 0; k < 300; k++) begin
      fp = $urandom;
      case ($urandom_range(0, 9))
        0:       fp[30:23] = 8'h00;
        1:       fp[30:23] = 8'hFF;
        default: fp[30:23] = 8'($urandom_range(110, 165));
      endcase
      run(fp, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
